// File: rtl/schedule_prog_mp_pkg.sv
// Shared constants and types for the multi-plane page program scheduler.
// Holds the NAND program opcodes, the default parameter values and the FSM state type.
package schedule_prog_mp_pkg;

  // Opcodes are {cmd2, cmd1}; 80h opens the program, 10h/11h confirms it.
  localparam logic [15:0] CMD_PROG_1080    = 16'h1080;
  localparam logic [15:0] CMD_PROG_MP_1180 = 16'h1180;

  localparam logic [11:0] PARAM_MID_DEFAULT = 12'h800;

  localparam int DEF_ID_W       = 16;
  localparam int DEF_ADDR_W     = 48;
  localparam int DEF_LEN_W      = 24;
  localparam int DEF_PAGE_BYTES = 2048;
  localparam int DEF_PAGE_LSB   = 0;
  localparam int DEF_PAGE_BITS  = 8;
  localparam int DEF_PLANE_BIT  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_ISSUE
  } state_t;

endpackage

// File: rtl/schedule_prog_mp_prog_addr_gen.sv
// Combinational page address and opcode generator.
// In two-plane mode pages are paired: the even page of a pair keeps the base
// plane and opens with 80h-11h, the odd page flips the plane and closes with
// 80h-10h. A lone trailing even page is issued as a plain single-plane program.
module prog_addr_gen
  import schedule_prog_mp_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int IDX_W     = DEF_LEN_W,
  parameter int PAGE_LSB  = DEF_PAGE_LSB,
  parameter int PAGE_BITS = DEF_PAGE_BITS,
  parameter int PLANE_BIT = DEF_PLANE_BIT
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [IDX_W-1:0]  page_idx,
  input  logic              mp_en,
  input  logic              last,
  output logic [ADDR_W-1:0] page_addr,
  output logic [15:0]       opcode
);

  logic [PAGE_BITS-1:0] page_field;

  // Replace the page field with base + offset (wrapping, no carry out) and set the plane bit.
  always_comb begin
    page_field = base[PAGE_LSB +: PAGE_BITS]
               + PAGE_BITS'(mp_en ? (page_idx >> 1) : page_idx);
    page_addr = base;
    page_addr[PAGE_LSB +: PAGE_BITS] = page_field;
    if (mp_en) begin
      page_addr[PLANE_BIT] = base[PLANE_BIT] ^ page_idx[0];
    end
    opcode = (mp_en && !page_idx[0] && !last) ? CMD_PROG_MP_1180 : CMD_PROG_1080;
  end

endmodule

// File: rtl/schedule_prog_mp.sv
// Host write command to page program scheduler.
// Splits one host write into page-sized program commands, waits until enough
// write data is buffered for each page, and hands each page to the page
// command stage over a valid/ready handshake. Optional two-plane pairing.
module schedule_prog_mp
  import schedule_prog_mp_pkg::*;
#(
  parameter int          ID_W       = DEF_ID_W,
  parameter int          ADDR_W     = DEF_ADDR_W,
  parameter int          LEN_W      = DEF_LEN_W,
  parameter int          PAGE_BYTES = DEF_PAGE_BYTES,
  parameter int          PAGE_LSB   = DEF_PAGE_LSB,
  parameter int          PAGE_BITS  = DEF_PAGE_BITS,
  parameter int          PLANE_BIT  = DEF_PLANE_BIT,
  parameter logic [11:0] PARAM_MID  = PARAM_MID_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [ID_W-1:0]   i_wcmd_id,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [LEN_W-1:0]  i_wlen,
  input  logic              i_mp_en,
  input  logic [LEN_W-1:0]  i_wdata_avail,
  input  logic              i_page_cmd_ready,
  output logic              o_page_cmd_valid,
  output logic [15:0]       o_page_cmd,
  output logic              o_page_cmd_last,
  output logic [ID_W-1:0]   o_page_cmd_id,
  output logic [ADDR_W-1:0] o_page_addr,
  output logic [31:0]       o_page_cmd_param,
  output logic              o_busy,
  output logic              o_cmd_done
);

  // One extra bit so chunk and issued+chunk never overflow in the data compare.
  localparam int CW = LEN_W + 1;
  localparam logic [CW-1:0] PAGE_CHUNK = CW'(PAGE_BYTES);

  state_t              state;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   base_q;
  logic                mp_q;
  logic [LEN_W-1:0]    remaining;
  logic [LEN_W-1:0]    issued;
  logic [LEN_W-1:0]    page_idx;

  logic [CW-1:0]       chunk;
  logic [CW-1:0]       need;
  logic                is_last;
  logic                data_ok;
  logic [ADDR_W-1:0]   gen_addr;
  logic [15:0]         gen_op;

  assign o_cmd_ready = (state == ST_IDLE);
  assign o_busy      = (state != ST_IDLE);

  // Size of the current page, the cumulative data it needs, and whether it ends the command.
  always_comb begin
    chunk   = ({1'b0, remaining} > PAGE_CHUNK) ? PAGE_CHUNK : {1'b0, remaining};
    need    = {1'b0, issued} + chunk;
    is_last = ({1'b0, remaining} == chunk);
    data_ok = ({1'b0, i_wdata_avail} >= need);
  end

  prog_addr_gen #(
    .ADDR_W    (ADDR_W),
    .IDX_W     (LEN_W),
    .PAGE_LSB  (PAGE_LSB),
    .PAGE_BITS (PAGE_BITS),
    .PLANE_BIT (PLANE_BIT)
  ) u_addr_gen (
    .base      (base_q),
    .page_idx  (page_idx),
    .mp_en     (mp_q),
    .last      (is_last),
    .page_addr (gen_addr),
    .opcode    (gen_op)
  );

  // Scheduler FSM: accept a command, wait for each page's data, hold the page until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      id_q             <= '0;
      base_q           <= '0;
      mp_q             <= 1'b0;
      remaining        <= '0;
      issued           <= '0;
      page_idx         <= '0;
      o_page_cmd_valid <= 1'b0;
      o_page_cmd       <= '0;
      o_page_cmd_last  <= 1'b0;
      o_page_cmd_id    <= '0;
      o_page_addr      <= '0;
      o_page_cmd_param <= '0;
      o_cmd_done       <= 1'b0;
    end else begin
      o_cmd_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_cmd_valid) begin
            id_q      <= i_wcmd_id;
            base_q    <= i_waddr;
            mp_q      <= i_mp_en;
            remaining <= i_wlen;
            issued    <= '0;
            page_idx  <= '0;
            if (i_wlen == '0) begin
              o_cmd_done <= 1'b1;
            end else begin
              state <= ST_WAIT_DATA;
            end
          end
        end
        ST_WAIT_DATA: begin
          if (data_ok) begin
            o_page_cmd_valid <= 1'b1;
            o_page_cmd       <= gen_op;
            o_page_cmd_last  <= is_last;
            o_page_cmd_id    <= id_q;
            o_page_addr      <= gen_addr;
            o_page_cmd_param <= {chunk[15:0], PARAM_MID, 3'h6, 1'b1};
            state            <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (i_page_cmd_ready) begin
            o_page_cmd_valid <= 1'b0;
            remaining        <= remaining - chunk[LEN_W-1:0];
            issued           <= issued + chunk[LEN_W-1:0];
            page_idx         <= page_idx + 1'b1;
            if (o_page_cmd_last) begin
              o_cmd_done <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              state <= ST_WAIT_DATA;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_schedule_prog_mp.sv
// Directed testbench for schedule_prog_mp with default parameters.
// Walks through single-plane, two-plane, starvation, backpressure, zero length
// and mid-command reset scenarios with hand-computed expected values.
module tb_schedule_prog_mp;

  logic        clk;
  logic        rst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [15:0] i_wcmd_id;
  logic [47:0] i_waddr;
  logic [23:0] i_wlen;
  logic        i_mp_en;
  logic [23:0] i_wdata_avail;
  logic        i_page_cmd_ready;
  logic        o_page_cmd_valid;
  logic [15:0] o_page_cmd;
  logic        o_page_cmd_last;
  logic [15:0] o_page_cmd_id;
  logic [47:0] o_page_addr;
  logic [31:0] o_page_cmd_param;
  logic        o_busy;
  logic        o_cmd_done;

  int checks = 0;
  int errors = 0;

  schedule_prog_mp dut (
    .clk              (clk),
    .rst              (rst),
    .i_cmd_valid      (i_cmd_valid),
    .o_cmd_ready      (o_cmd_ready),
    .i_wcmd_id        (i_wcmd_id),
    .i_waddr          (i_waddr),
    .i_wlen           (i_wlen),
    .i_mp_en          (i_mp_en),
    .i_wdata_avail    (i_wdata_avail),
    .i_page_cmd_ready (i_page_cmd_ready),
    .o_page_cmd_valid (o_page_cmd_valid),
    .o_page_cmd       (o_page_cmd),
    .o_page_cmd_last  (o_page_cmd_last),
    .o_page_cmd_id    (o_page_cmd_id),
    .o_page_addr      (o_page_addr),
    .o_page_cmd_param (o_page_cmd_param),
    .o_busy           (o_busy),
    .o_cmd_done       (o_cmd_done)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepClk(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one host command for exactly one cycle; returns just after the accept edge.
  task automatic applyStimulus(input logic [15:0] id, input logic [47:0] addr,
                               input logic [23:0] len, input logic mp);
    i_wcmd_id   = id;
    i_waddr     = addr;
    i_wlen      = len;
    i_mp_en     = mp;
    i_cmd_valid = 1'b1;
    stepClk();
    i_cmd_valid = 1'b0;
  endtask

  task automatic waitValid(input string tag, input int max_cycles);
    int n = 0;
    while (!o_page_cmd_valid && n < max_cycles) begin
      stepClk();
      n++;
    end
    checkOutput({tag, "_valid"}, 64'(o_page_cmd_valid), 64'd1);
  endtask

  task automatic checkPage(input string tag, input logic [15:0] cmd, input logic [47:0] addr,
                           input logic last, input logic [15:0] id, input logic [31:0] param);
    checkOutput({tag, "_cmd"},   64'(o_page_cmd),       64'(cmd));
    checkOutput({tag, "_addr"},  64'(o_page_addr),      64'(addr));
    checkOutput({tag, "_last"},  64'(o_page_cmd_last),  64'(last));
    checkOutput({tag, "_id"},    64'(o_page_cmd_id),    64'(id));
    checkOutput({tag, "_param"}, 64'(o_page_cmd_param), 64'(param));
  endtask

  initial begin
    rst              = 1'b1;
    i_cmd_valid      = 1'b0;
    i_wcmd_id        = '0;
    i_waddr          = '0;
    i_wlen           = '0;
    i_mp_en          = 1'b0;
    i_wdata_avail    = '0;
    i_page_cmd_ready = 1'b1;
    stepClk(2);

    $display("[TB] reset state");
    checkOutput("rst_valid", 64'(o_page_cmd_valid), 64'd0);
    checkOutput("rst_ready", 64'(o_cmd_ready),      64'd1);
    checkOutput("rst_busy",  64'(o_busy),           64'd0);
    checkOutput("rst_done",  64'(o_cmd_done),       64'd0);
    checkOutput("rst_cmd",   64'(o_page_cmd),       64'd0);
    checkOutput("rst_param", 64'(o_page_cmd_param), 64'd0);
    rst = 1'b0;
    stepClk();

    $display("[TB] single page, data present at accept");
    i_wdata_avail = 24'd2048;
    applyStimulus(16'h0011, 48'h0000_0000_0005, 24'd2048, 1'b0);
    checkOutput("t1_acc1_valid", 64'(o_page_cmd_valid), 64'd0);
    checkOutput("t1_acc1_busy",  64'(o_busy),           64'd1);
    checkOutput("t1_acc1_ready", 64'(o_cmd_ready),      64'd0);
    stepClk();
    checkOutput("t1_acc2_valid", 64'(o_page_cmd_valid), 64'd1);
    checkPage("t1", 16'h1080, 48'h0000_0000_0005, 1'b1, 16'h0011, 32'h0800_800D);
    stepClk();
    checkOutput("t1_post_valid", 64'(o_page_cmd_valid), 64'd0);
    checkOutput("t1_done",       64'(o_cmd_done),       64'd1);
    checkOutput("t1_ready",      64'(o_cmd_ready),      64'd1);
    stepClk();
    checkOutput("t1_done_pulse", 64'(o_cmd_done), 64'd0);

    $display("[TB] single plane, three pages with ramping data");
    i_wdata_avail = 24'd0;
    applyStimulus(16'h0022, 48'h0000_0000_0003, 24'd5000, 1'b0);
    stepClk(3);
    checkOutput("t2_starve_valid", 64'(o_page_cmd_valid), 64'd0);
    i_wdata_avail = 24'd2048;
    waitValid("t2_p0", 10);
    checkPage("t2_p0", 16'h1080, 48'h0000_0000_0003, 1'b0, 16'h0022, 32'h0800_800D);
    stepClk();
    checkOutput("t2_gap_valid", 64'(o_page_cmd_valid), 64'd0);
    checkOutput("t2_p0_done",   64'(o_cmd_done),       64'd0);
    i_wdata_avail = 24'd4096;
    waitValid("t2_p1", 10);
    checkPage("t2_p1", 16'h1080, 48'h0000_0000_0004, 1'b0, 16'h0022, 32'h0800_800D);
    stepClk();
    i_wdata_avail = 24'd5000;
    waitValid("t2_p2", 10);
    checkPage("t2_p2", 16'h1080, 48'h0000_0000_0005, 1'b1, 16'h0022, 32'h0388_800D);
    stepClk();
    checkOutput("t2_done", 64'(o_cmd_done), 64'd1);
    stepClk();

    $display("[TB] two-plane, three pages");
    i_wdata_avail = 24'd6144;
    applyStimulus(16'h0033, 48'h0000_0000_0007, 24'd6144, 1'b1);
    waitValid("t3_p0", 10);
    checkPage("t3_p0", 16'h1180, 48'h0000_0000_0007, 1'b0, 16'h0033, 32'h0800_800D);
    stepClk();
    waitValid("t3_p1", 10);
    checkPage("t3_p1", 16'h1080, 48'h0000_0001_0007, 1'b0, 16'h0033, 32'h0800_800D);
    stepClk();
    waitValid("t3_p2", 10);
    checkPage("t3_p2", 16'h1080, 48'h0000_0000_0008, 1'b1, 16'h0033, 32'h0800_800D);
    stepClk();
    checkOutput("t3_done", 64'(o_cmd_done), 64'd1);
    stepClk();

    $display("[TB] data starvation and page field wraparound");
    i_wdata_avail = 24'd2047;
    applyStimulus(16'h0044, 48'h1234_0001_00FF, 24'd4096, 1'b0);
    stepClk(5);
    checkOutput("t4_hold1_valid", 64'(o_page_cmd_valid), 64'd0);
    i_wdata_avail = 24'd2048;
    waitValid("t4_p0", 10);
    checkPage("t4_p0", 16'h1080, 48'h1234_0001_00FF, 1'b0, 16'h0044, 32'h0800_800D);
    stepClk();
    i_wdata_avail = 24'd4095;
    stepClk(5);
    checkOutput("t4_hold2_valid", 64'(o_page_cmd_valid), 64'd0);
    i_wdata_avail = 24'd4096;
    waitValid("t4_p1", 10);
    checkPage("t4_p1", 16'h1080, 48'h1234_0001_0000, 1'b1, 16'h0044, 32'h0800_800D);
    stepClk();
    checkOutput("t4_done", 64'(o_cmd_done), 64'd1);
    stepClk();

    $display("[TB] backpressure holds outputs stable");
    i_page_cmd_ready = 1'b0;
    i_wdata_avail    = 24'd2048;
    applyStimulus(16'h0055, 48'h0000_0000_0020, 24'd2048, 1'b0);
    waitValid("t5", 10);
    for (int i = 0; i < 5; i++) begin
      stepClk();
      checkOutput($sformatf("t5_hold%0d_valid", i), 64'(o_page_cmd_valid), 64'd1);
      checkPage($sformatf("t5_hold%0d", i), 16'h1080, 48'h0000_0000_0020, 1'b1,
                16'h0055, 32'h0800_800D);
      checkOutput($sformatf("t5_hold%0d_done", i), 64'(o_cmd_done), 64'd0);
    end
    i_page_cmd_ready = 1'b1;
    stepClk();
    checkOutput("t5_xfer_valid", 64'(o_page_cmd_valid), 64'd0);
    checkOutput("t5_done",       64'(o_cmd_done),       64'd1);
    stepClk();

    $display("[TB] zero-length command");
    applyStimulus(16'h0066, 48'h0000_0000_0030, 24'd0, 1'b0);
    checkOutput("t6_done",  64'(o_cmd_done),       64'd1);
    checkOutput("t6_valid", 64'(o_page_cmd_valid), 64'd0);
    checkOutput("t6_ready", 64'(o_cmd_ready),      64'd1);
    checkOutput("t6_busy",  64'(o_busy),           64'd0);
    stepClk();
    checkOutput("t6_done_pulse", 64'(o_cmd_done),       64'd0);
    checkOutput("t6_no_page",    64'(o_page_cmd_valid), 64'd0);

    $display("[TB] reset while a page is held");
    i_page_cmd_ready = 1'b0;
    i_wdata_avail    = 24'd4096;
    applyStimulus(16'h0077, 48'h0000_0000_0040, 24'd4096, 1'b0);
    waitValid("t7_pre", 10);
    rst = 1'b1;
    stepClk();
    rst = 1'b0;
    checkOutput("t7_rst_valid", 64'(o_page_cmd_valid), 64'd0);
    checkOutput("t7_rst_ready", 64'(o_cmd_ready),      64'd1);
    checkOutput("t7_rst_busy",  64'(o_busy),           64'd0);
    checkOutput("t7_rst_done",  64'(o_cmd_done),       64'd0);
    stepClk();
    checkOutput("t7_rst_nodone", 64'(o_cmd_done), 64'd0);
    i_page_cmd_ready = 1'b1;
    i_wdata_avail    = 24'd2048;
    applyStimulus(16'h0088, 48'h0000_0000_0050, 24'd2048, 1'b0);
    waitValid("t7_new", 10);
    checkPage("t7_new", 16'h1080, 48'h0000_0000_0050, 1'b1, 16'h0088, 32'h0800_800D);
    stepClk();
    checkOutput("t7_new_done", 64'(o_cmd_done), 64'd1);
    stepClk(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
